// File: rtl/vend_pkg.sv
// Shared constants, coin coding and FSM state type for the vending controller.
package vend_pkg;

    localparam int NUM_SLOTS  = 9;
    localparam int CREDIT_W   = 9;
    localparam int MAX_CREDIT = 500;
    localparam int STOCK_W    = 4;

    localparam logic [2:0] COIN_5   = 3'd0;
    localparam logic [2:0] COIN_10  = 3'd1;
    localparam logic [2:0] COIN_25  = 3'd2;
    localparam logic [2:0] COIN_50  = 3'd3;
    localparam logic [2:0] COIN_100 = 3'd4;
    localparam logic [2:0] COIN_500 = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CREDIT   = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REJECT   = 3'd4
    } state_t;

    // Face value in cents of a coin/bill code; invalid codes are worth nothing.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_5:   coin_value = 9'd5;
            COIN_10:  coin_value = 9'd10;
            COIN_25:  coin_value = 9'd25;
            COIN_50:  coin_value = 9'd50;
            COIN_100: coin_value = 9'd100;
            COIN_500: coin_value = 9'd500;
            default:  coin_value = 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Request/acknowledge handshakes toward the dispenser and the coin ejector.
interface vend_controller_if;
    logic       dispenseReq;
    logic [3:0] dispenseSlot;
    logic       dispenseAck;
    logic       ejectReq;
    logic [2:0] ejectType;
    logic       ejectAck;

    modport master (
        output dispenseReq, dispenseSlot, ejectReq, ejectType,
        input  dispenseAck, ejectAck
    );

    modport slave (
        input  dispenseReq, dispenseSlot, ejectReq, ejectType,
        output dispenseAck, ejectAck
    );
endinterface

// File: rtl/change_coin_sel.sv
// Greedy change picker: largest payable coin (500 bills excluded) not above credit.
module change_coin_sel
    import vend_pkg::*;
(
    input  logic [CREDIT_W-1:0] i_credit,
    output logic [2:0]          o_type,
    output logic [CREDIT_W-1:0] o_value
);

    // Walk the denominations from largest to smallest; value 0 means nothing fits.
    always_comb begin
        o_type  = COIN_5;
        o_value = {CREDIT_W{1'b0}};
        if (i_credit >= 9'd100) begin
            o_type  = COIN_100;
            o_value = coin_value(COIN_100);
        end else if (i_credit >= 9'd50) begin
            o_type  = COIN_50;
            o_value = coin_value(COIN_50);
        end else if (i_credit >= 9'd25) begin
            o_type  = COIN_25;
            o_value = coin_value(COIN_25);
        end else if (i_credit >= 9'd10) begin
            o_type  = COIN_10;
            o_value = coin_value(COIN_10);
        end else if (i_credit >= 9'd5) begin
            o_type  = COIN_5;
            o_value = coin_value(COIN_5);
        end else begin
            o_type  = COIN_5;
            o_value = {CREDIT_W{1'b0}};
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit, slot table, selection arbitration,
// dispense/eject handshakes and greedy change payout.
module vend_controller
    import vend_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 coinValid,
    input  logic [2:0]           coinType,
    input  logic                 selValid,
    input  logic [3:0]           selSlot,
    input  logic                 cancel,
    input  logic                 cfgWe,
    input  logic [3:0]           cfgSlot,
    input  logic [CREDIT_W-1:0]  cfgPrice,
    input  logic [STOCK_W-1:0]   cfgStock,
    vend_controller_if.master    hs,
    output logic [CREDIT_W-1:0]  credit,
    output logic [CREDIT_W-1:0]  displayVal,
    output logic [NUM_SLOTS-1:0] availMask,
    output logic [NUM_SLOTS-1:0] oosMask,
    output logic                 busy
);

    localparam logic [3:0]        SLOT_LIMIT   = 4'(NUM_SLOTS);
    localparam logic [CREDIT_W:0] CREDIT_LIMIT = (CREDIT_W+1)'(MAX_CREDIT);

    state_t               r_state, w_state_nxt;
    logic [CREDIT_W-1:0]  r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0]  r_last_price, w_last_price_nxt;
    logic [CREDIT_W-1:0]  r_price [NUM_SLOTS];
    logic [STOCK_W-1:0]   r_stock [NUM_SLOTS];
    logic                 r_disp_req, w_disp_req_nxt;
    logic [3:0]           r_disp_slot, w_disp_slot_nxt;
    logic                 r_ej_req, w_ej_req_nxt;
    logic [2:0]           r_ej_type, w_ej_type_nxt;
    logic [CREDIT_W-1:0]  r_display;
    logic                 r_busy;
    logic                 w_dec_en;

    logic                 w_sel_ev, w_coin_ev, w_cfg_en, w_coin_fits;
    logic [3:0]           w_sel_idx;
    logic [CREDIT_W-1:0]  w_sel_price, w_coin_val, w_ej_val, w_chg_val;
    logic [STOCK_W-1:0]   w_sel_stock;
    logic [CREDIT_W:0]    w_credit_sum;
    logic [2:0]           w_chg_type;

    // Event priority: cancel masks selection, selection masks coins.
    assign w_sel_ev     = selValid && !cancel && (selSlot < SLOT_LIMIT);
    assign w_sel_idx    = (selSlot < SLOT_LIMIT) ? selSlot : 4'd0;
    assign w_sel_price  = r_price[w_sel_idx];
    assign w_sel_stock  = r_stock[w_sel_idx];
    assign w_coin_val   = coin_value(coinType);
    assign w_coin_ev    = coinValid && !cancel && !selValid && (w_coin_val != 9'd0);
    assign w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_fits  = (w_credit_sum <= CREDIT_LIMIT);
    assign w_cfg_en     = cfgWe && (r_state == ST_IDLE) && (cfgSlot < SLOT_LIMIT);
    assign w_ej_val     = coin_value(r_ej_type);

    change_coin_sel u_change_coin_sel (
        .i_credit (r_credit),
        .o_type   (w_chg_type),
        .o_value  (w_chg_val)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath decisions for every state.
    always_comb begin
        w_state_nxt      = r_state;
        w_credit_nxt     = r_credit;
        w_last_price_nxt = r_last_price;
        w_disp_req_nxt   = r_disp_req;
        w_disp_slot_nxt  = r_disp_slot;
        w_ej_req_nxt     = r_ej_req;
        w_ej_type_nxt    = r_ej_type;
        w_dec_en         = 1'b0;

        if (w_sel_ev) begin
            w_last_price_nxt = w_sel_price;
        end else begin
            w_last_price_nxt = r_last_price;
        end

        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                if (cancel) begin
                    if (r_state == ST_CREDIT) begin
                        w_state_nxt = ST_CHANGE;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else if (w_sel_ev) begin
                    if ((r_state == ST_CREDIT) && (w_sel_price != 9'd0) &&
                        (w_sel_stock != 4'd0) && (r_credit >= w_sel_price)) begin
                        w_credit_nxt    = r_credit - w_sel_price;
                        w_disp_slot_nxt = selSlot;
                        w_disp_req_nxt  = 1'b1;
                        w_state_nxt     = ST_DISPENSE;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else if (w_coin_ev) begin
                    if (w_coin_fits) begin
                        w_credit_nxt = w_credit_sum[CREDIT_W-1:0];
                        w_state_nxt  = ST_CREDIT;
                    end else begin
                        w_ej_req_nxt  = 1'b1;
                        w_ej_type_nxt = coinType;
                        w_state_nxt   = ST_REJECT;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_DISPENSE: begin
                if (r_disp_req && hs.dispenseAck) begin
                    w_disp_req_nxt = 1'b0;
                    w_dec_en       = 1'b1;
                    w_state_nxt    = (r_credit != 9'd0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    w_state_nxt = ST_DISPENSE;
                end
            end
            ST_CHANGE: begin
                if (r_ej_req) begin
                    if (hs.ejectAck) begin
                        w_ej_req_nxt = 1'b0;
                        w_credit_nxt = r_credit - w_ej_val;
                        w_state_nxt  = (r_credit == w_ej_val) ? ST_IDLE : ST_CHANGE;
                    end else begin
                        w_state_nxt = ST_CHANGE;
                    end
                end else if (w_chg_val == 9'd0) begin
                    // Remainder below the smallest coin cannot be paid out.
                    w_credit_nxt = {CREDIT_W{1'b0}};
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_ej_req_nxt  = 1'b1;
                    w_ej_type_nxt = w_chg_type;
                end
            end
            ST_REJECT: begin
                if (r_ej_req && hs.ejectAck) begin
                    w_ej_req_nxt = 1'b0;
                    w_state_nxt  = (r_credit != 9'd0) ? ST_CREDIT : ST_IDLE;
                end else begin
                    w_state_nxt = ST_REJECT;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_disp_req_nxt = 1'b0;
                w_ej_req_nxt   = 1'b0;
            end
        endcase
    end

    // Registered credit, handshake outputs, display value and busy flag.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_credit     <= {CREDIT_W{1'b0}};
            r_last_price <= {CREDIT_W{1'b0}};
            r_disp_req   <= 1'b0;
            r_disp_slot  <= 4'd0;
            r_ej_req     <= 1'b0;
            r_ej_type    <= 3'd0;
            r_display    <= {CREDIT_W{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            r_credit     <= w_credit_nxt;
            r_last_price <= w_last_price_nxt;
            r_disp_req   <= w_disp_req_nxt;
            r_disp_slot  <= w_disp_slot_nxt;
            r_ej_req     <= w_ej_req_nxt;
            r_ej_type    <= w_ej_type_nxt;
            r_display    <= (w_credit_nxt != 9'd0) ? w_credit_nxt : w_last_price_nxt;
            r_busy       <= (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CHANGE) ||
                            (w_state_nxt == ST_REJECT);
        end
    end

    // Per-slot price/stock table: configuration writes and post-dispense decrement.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!resetN) begin
                r_price[i] <= {CREDIT_W{1'b0}};
                r_stock[i] <= {STOCK_W{1'b0}};
            end else if (w_cfg_en && (cfgSlot == 4'(i))) begin
                r_price[i] <= cfgPrice;
                r_stock[i] <= cfgStock;
            end else if (w_dec_en && (r_disp_slot == 4'(i))) begin
                r_stock[i] <= r_stock[i] - STOCK_W'(1);
            end else begin
                r_stock[i] <= r_stock[i];
            end
        end
    end

    // Slot LEDs derived directly from the table and current credit.
    always_comb begin
        availMask = {NUM_SLOTS{1'b0}};
        oosMask   = {NUM_SLOTS{1'b0}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            availMask[i] = (r_price[i] != 9'd0) && (r_stock[i] != 4'd0) && (r_credit >= r_price[i]);
            oosMask[i]   = (r_price[i] == 9'd0) || (r_stock[i] == 4'd0);
        end
    end

    assign hs.dispenseReq  = r_disp_req;
    assign hs.dispenseSlot = r_disp_slot;
    assign hs.ejectReq     = r_ej_req;
    assign hs.ejectType    = r_ej_type;
    assign credit          = r_credit;
    assign displayVal      = r_display;
    assign busy            = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus a
// randomized session checked against a transaction-level model.
module tb_vend_controller;
    import vend_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 resetN, coinValid, selValid, cancel, cfgWe;
    logic [2:0]           coinType;
    logic [3:0]           selSlot, cfgSlot;
    logic [CREDIT_W-1:0]  cfgPrice;
    logic [STOCK_W-1:0]   cfgStock;
    logic [CREDIT_W-1:0]  credit, displayVal;
    logic [NUM_SLOTS-1:0] availMask, oosMask;
    logic                 busy;

    vend_controller_if hs();

    vend_controller dut (
        .clk(clk), .resetN(resetN), .coinValid(coinValid), .coinType(coinType),
        .selValid(selValid), .selSlot(selSlot), .cancel(cancel), .cfgWe(cfgWe),
        .cfgSlot(cfgSlot), .cfgPrice(cfgPrice), .cfgStock(cfgStock), .hs(hs),
        .credit(credit), .displayVal(displayVal), .availMask(availMask),
        .oosMask(oosMask), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int got_disp[$], got_ej[$], exp_disp[$], exp_ej[$];

    // Model of the machine as seen between transactions.
    int m_credit, m_last;
    int m_price [NUM_SLOTS];
    int m_stock [NUM_SLOTS];

    function automatic int cval(input int code);
        case (code)
            0: return 5;   1: return 10;  2: return 25;
            3: return 50;  4: return 100; 5: return 500;
            default: return 0;
        endcase
    endfunction

    // Expected change coins: greedy over 100/50/25/10/5.
    function automatic void m_greedy(input int amt);
        int d [5];
        int c [5];
        d = '{100, 50, 25, 10, 5};
        c = '{4, 3, 2, 1, 0};
        for (int i = 0; i < 5; i++) begin
            while (amt >= d[i]) begin
                exp_ej.push_back(c[i]);
                amt -= d[i];
            end
        end
    endfunction

    function automatic logic [NUM_SLOTS-1:0] m_avail();
        logic [NUM_SLOTS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            v[i] = (m_price[i] != 0) && (m_stock[i] != 0) && (m_credit >= m_price[i]);
        return v;
    endfunction

    function automatic logic [NUM_SLOTS-1:0] m_oos();
        logic [NUM_SLOTS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            v[i] = (m_price[i] == 0) || (m_stock[i] == 0);
        return v;
    endfunction

    function automatic bit q_eq(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input int q[$]);
        string s;
        s = "{";
        foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
        return {s, " }"};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_coin(input int t);
        coinValid = 1'b1; coinType = 3'(t);
        tick();
        coinValid = 1'b0;
    endtask

    task automatic press(input int s);
        selValid = 1'b1; selSlot = 4'(s);
        tick();
        selValid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic cfg(input int s, input int p, input int st);
        cfgWe = 1'b1; cfgSlot = 4'(s); cfgPrice = CREDIT_W'(p); cfgStock = STOCK_W'(st);
        tick();
        cfgWe = 1'b0;
    endtask

    // Acts as dispenser and ejector: acks each request after 0..2 cycles,
    // sometimes pulses a stray ack while no request is up, records what was served.
    task automatic service(input int budget, output bit to);
        int n;
        n = 0; to = 1'b0;
        while (busy === 1'b1) begin
            if (n >= budget) begin
                to = 1'b1;
                break;
            end
            if (hs.dispenseReq === 1'b1) begin
                repeat ($urandom_range(0, 2)) begin tick(); n++; end
                got_disp.push_back(int'(hs.dispenseSlot));
                hs.dispenseAck = 1'b1; tick(); hs.dispenseAck = 1'b0; n++;
            end else if (hs.ejectReq === 1'b1) begin
                repeat ($urandom_range(0, 2)) begin tick(); n++; end
                got_ej.push_back(int'(hs.ejectType));
                hs.ejectAck = 1'b1; tick(); hs.ejectAck = 1'b0; n++;
            end else begin
                hs.ejectAck    = ($urandom_range(0, 3) == 0);
                hs.dispenseAck = ($urandom_range(0, 3) == 0);
                tick(); n++;
                hs.ejectAck = 1'b0; hs.dispenseAck = 1'b0;
            end
        end
    endtask

    task automatic clear_q();
        got_disp.delete(); got_ej.delete(); exp_disp.delete(); exp_ej.delete();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) tick();
        resetN = 1'b1;
        tick();
        n_checks++; if (credit !== 9'd0) begin n_fail++; $display("FAIL reset_credit got %0d want 0", credit); end
        n_checks++; if (displayVal !== 9'd0) begin n_fail++; $display("FAIL reset_display got %0d want 0", displayVal); end
        n_checks++; if (hs.dispenseReq !== 1'b0 || hs.ejectReq !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b%b want 00", hs.dispenseReq, hs.ejectReq); end
        n_checks++; if (hs.dispenseSlot !== 4'd0 || hs.ejectType !== 3'd0) begin n_fail++; $display("FAIL reset_slot_type got %0d/%0d want 0/0", hs.dispenseSlot, hs.ejectType); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (oosMask !== 9'h1FF) begin n_fail++; $display("FAIL reset_oos got %b want 111111111", oosMask); end
        n_checks++; if (availMask !== 9'h000) begin n_fail++; $display("FAIL reset_avail got %b want 0", availMask); end
    endtask

    task automatic test_basic_purchase();
        bit to;
        clear_q();
        cfg(0, 75, 2);
        insert_coin(3);
        insert_coin(2);
        n_checks++; if (credit !== 9'd75) begin n_fail++; $display("FAIL basic_credit got %0d want 75", credit); end
        n_checks++; if (availMask[0] !== 1'b1) begin n_fail++; $display("FAIL basic_avail0 got %b want 1", availMask[0]); end
        press(0);
        n_checks++; if (hs.dispenseReq !== 1'b1 || hs.dispenseSlot !== 4'd0) begin n_fail++; $display("FAIL basic_req got %b/%0d want 1/0", hs.dispenseReq, hs.dispenseSlot); end
        service(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout got busy want idle"); end
        exp_disp = '{0};
        n_checks++; if (!q_eq(got_disp, exp_disp) || got_ej.size() != 0) begin n_fail++; $display("FAIL basic_served got %s/%s want {0}/{}", q_str(got_disp), q_str(got_ej)); end
        n_checks++; if (oosMask[0] !== 1'b0 || availMask[0] !== 1'b0 || displayVal !== 9'd75) begin n_fail++; $display("FAIL basic_after got oos%b av%b disp%0d want 0 0 75", oosMask[0], availMask[0], displayVal); end
    endtask

    task automatic test_change();
        bit to;
        clear_q();
        cfg(1, 35, 3);
        insert_coin(4);
        press(1);
        n_checks++; if (hs.dispenseReq !== 1'b1 || hs.dispenseSlot !== 4'd1 || credit !== 9'd65) begin n_fail++; $display("FAIL change_req got %b/%0d/%0d want 1/1/65", hs.dispenseReq, hs.dispenseSlot, credit); end
        service(200, to);
        exp_disp = '{1}; exp_ej = '{3, 1, 0};
        n_checks++; if (to || !q_eq(got_disp, exp_disp) || !q_eq(got_ej, exp_ej)) begin n_fail++; $display("FAIL change_coins got %s/%s to=%0d want {1}/{3 1 0}", q_str(got_disp), q_str(got_ej), to); end
        n_checks++; if (credit !== 9'd0 || busy !== 1'b0 || displayVal !== 9'd35) begin n_fail++; $display("FAIL change_end got cr%0d busy%b disp%0d want 0 0 35", credit, busy, displayVal); end
    endtask

    task automatic test_reject();
        bit to;
        clear_q();
        insert_coin(4); insert_coin(4); insert_coin(4); insert_coin(4); insert_coin(3);
        n_checks++; if (credit !== 9'd450) begin n_fail++; $display("FAIL reject_pre got %0d want 450", credit); end
        insert_coin(4);
        n_checks++; if (hs.ejectReq !== 1'b1 || hs.ejectType !== 3'd4 || credit !== 9'd450 || busy !== 1'b1) begin n_fail++; $display("FAIL reject_req got %b/%0d/%0d/%b want 1/4/450/1", hs.ejectReq, hs.ejectType, credit, busy); end
        service(200, to);
        exp_ej = '{4};
        n_checks++; if (to || !q_eq(got_ej, exp_ej) || credit !== 9'd450 || busy !== 1'b0) begin n_fail++; $display("FAIL reject_done got %s cr%0d busy%b want {4} 450 0", q_str(got_ej), credit, busy); end
        clear_q();
        do_cancel();
        service(300, to);
        exp_ej = '{4, 4, 4, 4, 3};
        n_checks++; if (to || !q_eq(got_ej, exp_ej) || credit !== 9'd0) begin n_fail++; $display("FAIL reject_refund got %s cr%0d want {4 4 4 4 3} 0", q_str(got_ej), credit); end
    endtask

    task automatic test_cancel_cfg();
        bit to;
        clear_q();
        insert_coin(3); insert_coin(1); insert_coin(0);
        do_cancel();
        n_checks++; if (busy !== 1'b1 || credit !== 9'd65) begin n_fail++; $display("FAIL cancel_enter got busy%b cr%0d want 1 65", busy, credit); end
        cfg(2, 10, 5);
        service(200, to);
        exp_ej = '{3, 1, 0};
        n_checks++; if (to || !q_eq(got_ej, exp_ej) || credit !== 9'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL cancel_coins got %s cr%0d want {3 1 0} 0", q_str(got_ej), credit); end
        n_checks++; if (oosMask[2] !== 1'b1) begin n_fail++; $display("FAIL cancel_cfg_dropped got oos2=%b want 1", oosMask[2]); end
    endtask

    task automatic test_refused_selection();
        bit to;
        clear_q();
        insert_coin(1); insert_coin(1);
        press(0);
        n_checks++; if (hs.dispenseReq !== 1'b0 || busy !== 1'b0 || credit !== 9'd20 || displayVal !== 9'd20) begin n_fail++; $display("FAIL short_credit got req%b busy%b cr%0d disp%0d want 0 0 20 20", hs.dispenseReq, busy, credit, displayVal); end
        do_cancel();
        service(200, to);
        exp_ej = '{1, 1};
        n_checks++; if (to || !q_eq(got_ej, exp_ej) || displayVal !== 9'd75) begin n_fail++; $display("FAIL short_refund got %s disp%0d want {1 1} 75", q_str(got_ej), displayVal); end
        clear_q();
        cfg(3, 25, 0);
        n_checks++; if (oosMask[3] !== 1'b1) begin n_fail++; $display("FAIL stock0_oos got %b want 1", oosMask[3]); end
        insert_coin(2);
        press(3);
        n_checks++; if (hs.dispenseReq !== 1'b0 || busy !== 1'b0 || credit !== 9'd25) begin n_fail++; $display("FAIL stock0_sel got req%b busy%b cr%0d want 0 0 25", hs.dispenseReq, busy, credit); end
        do_cancel();
        service(200, to);
        exp_ej = '{2};
        n_checks++; if (to || !q_eq(got_ej, exp_ej)) begin n_fail++; $display("FAIL stock0_refund got %s want {2}", q_str(got_ej)); end
    endtask

    task automatic test_cancel_priority();
        bit to;
        clear_q();
        insert_coin(3);
        cancel = 1'b1; selValid = 1'b1; selSlot = 4'd1;
        tick();
        cancel = 1'b0; selValid = 1'b0;
        n_checks++; if (busy !== 1'b1 || hs.dispenseReq !== 1'b0 || credit !== 9'd50) begin n_fail++; $display("FAIL prio_enter got busy%b req%b cr%0d want 1 0 50", busy, hs.dispenseReq, credit); end
        service(200, to);
        exp_ej = '{3};
        n_checks++; if (to || got_disp.size() != 0 || !q_eq(got_ej, exp_ej)) begin n_fail++; $display("FAIL prio_served got %s/%s want {}/{3}", q_str(got_disp), q_str(got_ej)); end
    endtask

    task automatic test_reset_mid();
        insert_coin(4);
        press(1);
        n_checks++; if (hs.dispenseReq !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got %b want 1", hs.dispenseReq); end
        resetN = 1'b0;
        tick();
        n_checks++; if (hs.dispenseReq !== 1'b0 || credit !== 9'd0 || busy !== 1'b0 || oosMask !== 9'h1FF) begin n_fail++; $display("FAIL midrst got req%b cr%0d busy%b oos%b want 0 0 0 111111111", hs.dispenseReq, credit, busy, oosMask); end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit to;
        int op, t, s, p, st;
        resetN = 1'b0; tick(); resetN = 1'b1; tick();
        m_credit = 0; m_last = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_price[i] = 5 * $urandom_range(0, 30);
            m_stock[i] = $urandom_range(0, 3);
            cfg(i, m_price[i], m_stock[i]);
        end
        n_checks++; if (oosMask !== m_oos()) begin n_fail++; $display("FAIL rand_cfg_oos got %b want %b", oosMask, m_oos()); end
        for (int k = 0; k < 80; k++) begin
            clear_q();
            op = $urandom_range(0, 99);
            if (op < 50) begin
                t = $urandom_range(0, 7);
                insert_coin(t);
                if (cval(t) != 0) begin
                    if (m_credit + cval(t) <= MAX_CREDIT) m_credit += cval(t);
                    else exp_ej.push_back(t);
                end
            end else if (op < 80) begin
                s = $urandom_range(0, 11);
                press(s);
                if (s < NUM_SLOTS) begin
                    m_last = m_price[s];
                    if (m_credit > 0 && m_price[s] != 0 && m_stock[s] != 0 && m_credit >= m_price[s]) begin
                        m_credit -= m_price[s];
                        m_stock[s]--;
                        exp_disp.push_back(s);
                        m_greedy(m_credit);
                        m_credit = 0;
                    end
                end
            end else if (op < 90) begin
                do_cancel();
                if (m_credit > 0) begin
                    m_greedy(m_credit);
                    m_credit = 0;
                end
            end else begin
                s = $urandom_range(0, NUM_SLOTS - 1);
                p = 5 * $urandom_range(0, 30);
                st = $urandom_range(0, 3);
                cfg(s, p, st);
                if (m_credit == 0) begin
                    m_price[s] = p;
                    m_stock[s] = st;
                end
            end
            service(300, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL rand_timeout op%0d got busy want idle", k); end
            n_checks++; if (!q_eq(got_disp, exp_disp)) begin n_fail++; $display("FAIL rand_disp op%0d got %s want %s", k, q_str(got_disp), q_str(exp_disp)); end
            n_checks++; if (!q_eq(got_ej, exp_ej)) begin n_fail++; $display("FAIL rand_eject op%0d got %s want %s", k, q_str(got_ej), q_str(exp_ej)); end
            n_checks++; if (int'(credit) != m_credit) begin n_fail++; $display("FAIL rand_credit op%0d got %0d want %0d", k, credit, m_credit); end
            n_checks++; if (int'(displayVal) != ((m_credit > 0) ? m_credit : m_last)) begin n_fail++; $display("FAIL rand_display op%0d got %0d want %0d", k, displayVal, (m_credit > 0) ? m_credit : m_last); end
            n_checks++; if (availMask !== m_avail() || oosMask !== m_oos()) begin n_fail++; $display("FAIL rand_masks op%0d got %b/%b want %b/%b", k, availMask, oosMask, m_avail(), m_oos()); end
        end
    endtask

    initial begin
        resetN = 1'b0; coinValid = 1'b0; coinType = 3'd0; selValid = 1'b0; selSlot = 4'd0;
        cancel = 1'b0; cfgWe = 1'b0; cfgSlot = 4'd0; cfgPrice = '0; cfgStock = '0;
        hs.dispenseAck = 1'b0; hs.ejectAck = 1'b0;
        test_reset();
        test_basic_purchase();
        test_change();
        test_reject();
        test_cancel_cfg();
        test_refused_selection();
        test_cancel_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
